// File: rtl/video_pattern_tx.sv
// video_pattern_tx
//   Test-pattern video source producing frames in the di/de/hs/vs protocol
//   used by the scaler chain. A falling hs marks a line start and a rising vs
//   marks a frame start. Geometry, blanking and pattern are copied into
//   shadow registers at every frame boundary, so register writes made while
//   a frame is running only take effect on the next frame.
//
// Parameters
//   PIXEL_WIDTH  width of the pixel data bus
//   SPARSE       idle cycles inserted after every valid pixel of a line
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   reg_en          enable, only looked at when a frame could start
//   reg_pattern     0 h-ramp, 1 v-ramp, 2 8x8 checkerboard, 3 constant
//   reg_const       pixel value used by the constant pattern
//   reg_pix_count   active pixels per line
//   reg_line_count  active lines per frame
//   reg_hblank      hs=1 cycles before every line (0 behaves as 1)
//   reg_vblank      vertical blank cycles before the first line (0 behaves as 1)
//   do_o, de_o      pixel data and pixel valid (data forced to 0 when not valid)
//   hs_o, vs_o      horizontal / vertical sync as described above
//   busy_o          high whenever a frame is in progress
//   frame_end_o     single-cycle pulse on the last active cycle of a frame
module video_pattern_tx #(
    parameter int PIXEL_WIDTH = 12,
    parameter int SPARSE      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_en,
    input  logic [1:0]             reg_pattern,
    input  logic [PIXEL_WIDTH-1:0] reg_const,
    input  logic [15:0]            reg_pix_count,
    input  logic [15:0]            reg_line_count,
    input  logic [15:0]            reg_hblank,
    input  logic [15:0]            reg_vblank,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   busy_o,
    output logic                   frame_end_o
);

    // Phase counter walks through the SPARSE+1 cycles that belong to one pixel.
    localparam int PH_W = (SPARSE > 0) ? $clog2(SPARSE + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPARSE);

    typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            x_q, x_d;
    logic [15:0]            y_q, y_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [15:0]            sh_pix_q, sh_pix_d;
    logic [15:0]            sh_lines_q, sh_lines_d;
    logic [15:0]            sh_hblank_q, sh_hblank_d;
    logic [1:0]             sh_pattern_q, sh_pattern_d;
    logic [PIXEL_WIDTH-1:0] sh_const_q, sh_const_d;

    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   busy_q, busy_d;
    logic                   frame_end_q, frame_end_d;

    logic                   start_ok;
    logic                   relatch;
    logic                   last_pix;
    logic                   last_line;
    logic [PIXEL_WIDTH-1:0] pix_val;

    // State, counters, shadow configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ph_q         <= '0;
            sh_pix_q     <= '0;
            sh_lines_q   <= '0;
            sh_hblank_q  <= '0;
            sh_pattern_q <= '0;
            sh_const_q   <= '0;
            do_q         <= '0;
            de_q         <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ph_q         <= ph_d;
            sh_pix_q     <= sh_pix_d;
            sh_lines_q   <= sh_lines_d;
            sh_hblank_q  <= sh_hblank_d;
            sh_pattern_q <= sh_pattern_d;
            sh_const_q   <= sh_const_d;
            do_q         <= do_d;
            de_q         <= de_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            busy_q       <= busy_d;
            frame_end_q  <= frame_end_d;
        end
    end

    // Next-state logic. Blank phases count down from length-1 so that a
    // 16'hFFFF setting never needs a 17-bit compare; pixel/line terminals are
    // compared against count-1, which is safe because zero counts never start
    // a frame.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        ph_d         = ph_q;
        sh_pix_d     = sh_pix_q;
        sh_lines_d   = sh_lines_q;
        sh_hblank_d  = sh_hblank_q;
        sh_pattern_d = sh_pattern_q;
        sh_const_d   = sh_const_q;
        relatch      = 1'b0;
        start_ok     = reg_en && (reg_pix_count != 16'd0) && (reg_line_count != 16'd0);
        last_pix     = (x_q == sh_pix_q - 16'd1) && (ph_q == PH_LAST);
        last_line    = (y_q == sh_lines_q - 16'd1);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    relatch = 1'b1;
                end
            end
            VBLANK: begin
                if (cnt_q == 16'd0) begin
                    state_d = HBLANK;
                    cnt_d   = sh_hblank_q - 16'd1;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HBLANK: begin
                if (cnt_q == 16'd0) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    ph_d    = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ACTIVE: begin
                if (!last_pix) begin
                    if (ph_q != PH_LAST) begin
                        ph_d = ph_q + PH_W'(1);
                    end else begin
                        ph_d = '0;
                        x_d  = x_q + 16'd1;
                    end
                end else if (!last_line) begin
                    state_d = HBLANK;
                    cnt_d   = sh_hblank_q - 16'd1;
                    y_d     = y_q + 16'd1;
                end else if (start_ok) begin
                    relatch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering vertical blank: take a fresh copy of the configuration,
        // clamping zero blanking lengths to a single cycle.
        if (relatch) begin
            state_d      = VBLANK;
            cnt_d        = (reg_vblank == 16'd0) ? 16'd0 : reg_vblank - 16'd1;
            sh_pix_d     = reg_pix_count;
            sh_lines_d   = reg_line_count;
            sh_hblank_d  = (reg_hblank == 16'd0) ? 16'd1 : reg_hblank;
            sh_pattern_d = reg_pattern;
            sh_const_d   = reg_const;
        end
    end

    // Output decode from the next state so every output is a plain flop.
    // Shadows are only rewritten on entry to VBLANK, so the current shadow
    // values are the right ones whenever the next state is ACTIVE.
    always_comb begin
        de_d        = (state_d == ACTIVE) && (ph_d == '0);
        hs_d        = (state_d == VBLANK) || (state_d == HBLANK);
        vs_d        = (state_d == HBLANK) || (state_d == ACTIVE);
        busy_d      = (state_d != IDLE);
        frame_end_d = (state_d == ACTIVE) && (x_d == sh_pix_q - 16'd1) &&
                      (ph_d == PH_LAST) && (y_d == sh_lines_q - 16'd1);
        case (sh_pattern_q)
            2'd0:    pix_val = PIXEL_WIDTH'(x_d);
            2'd1:    pix_val = PIXEL_WIDTH'(y_d);
            2'd2:    pix_val = (x_d[3] ^ y_d[3]) ? {PIXEL_WIDTH{1'b1}} : '0;
            default: pix_val = sh_const_q;
        endcase
        do_d = de_d ? pix_val : '0;
    end

    assign do_o        = do_q;
    assign de_o        = de_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign busy_o      = busy_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: tb/tb_video_pattern_tx.sv
// tb_video_pattern_tx
//   Drives two generators (SPARSE=0 and SPARSE=2) from the same register
//   inputs. A frame-level model builds the expected output stream for each
//   instance whenever its previous stream runs out, using the inputs as they
//   are at that moment, and every cycle is compared against it.
module tb_video_pattern_tx;

    localparam int PW       = 12;
    localparam int ALL_ONES = (1 << PW) - 1;

    typedef struct {
        logic [PW-1:0] dout;
        logic          de;
        logic          hs;
        logic          vs;
        logic          busy;
        logic          fe;
    } exp_t;

    typedef struct {
        int pix;
        int lines;
        int hb;
        int vb;
        int pat;
        int cst;
        int len0;
        int len2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reg_en;
    logic [1:0]    reg_pattern;
    logic [PW-1:0] reg_const;
    logic [15:0]   reg_pix_count;
    logic [15:0]   reg_line_count;
    logic [15:0]   reg_hblank;
    logic [15:0]   reg_vblank;

    logic [PW-1:0] do0, do2;
    logic          de0, hs0, vs0, busy0, fe0;
    logic          de2, hs2, vs2, busy2, fe2;

    exp_t q0[$];
    exp_t q2[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    always #5 clk = ~clk;

    video_pattern_tx #(.PIXEL_WIDTH(PW), .SPARSE(0)) dut0 (
        .clk(clk), .rst(rst), .reg_en(reg_en), .reg_pattern(reg_pattern),
        .reg_const(reg_const), .reg_pix_count(reg_pix_count),
        .reg_line_count(reg_line_count), .reg_hblank(reg_hblank),
        .reg_vblank(reg_vblank), .do_o(do0), .de_o(de0), .hs_o(hs0),
        .vs_o(vs0), .busy_o(busy0), .frame_end_o(fe0)
    );

    video_pattern_tx #(.PIXEL_WIDTH(PW), .SPARSE(2)) dut2 (
        .clk(clk), .rst(rst), .reg_en(reg_en), .reg_pattern(reg_pattern),
        .reg_const(reg_const), .reg_pix_count(reg_pix_count),
        .reg_line_count(reg_line_count), .reg_hblank(reg_hblank),
        .reg_vblank(reg_vblank), .do_o(do2), .de_o(de2), .hs_o(hs2),
        .vs_o(vs2), .busy_o(busy2), .frame_end_o(fe2)
    );

    // Pixel value at column x, row y, straight from the pattern definitions.
    function automatic logic [PW-1:0] pixelValue(input int pat, input int cst, input int x, input int y);
        int v;
        case (pat)
            0:       v = x % (1 << PW);
            1:       v = y % (1 << PW);
            2:       v = (((x / 8) % 2) != ((y / 8) % 2)) ? ALL_ONES : 0;
            default: v = cst;
        endcase
        return v[PW-1:0];
    endfunction

    function automatic exp_t mk(input logic de, input logic hs, input logic vs,
                                input logic busy, input logic fe, input logic [PW-1:0] d);
        exp_t e;
        e.dout = d;
        e.de   = de;
        e.hs   = hs;
        e.vs   = vs;
        e.busy = busy;
        e.fe   = fe;
        return e;
    endfunction

    function automatic void pushExp(input int which, input exp_t e);
        if (which == 0) q0.push_back(e);
        else            q2.push_back(e);
    endfunction

    // Expected stream from the next clock edge onward: a whole frame if the
    // inputs allow one to start, otherwise a single idle cycle.
    function automatic void modelRefill(input int which, input int sparse);
        int   pix, lines, hb, vb, pat, cst, span;
        logic de;
        pix   = int'(reg_pix_count);
        lines = int'(reg_line_count);
        if (!reg_en || pix == 0 || lines == 0) begin
            pushExp(which, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
            return;
        end
        hb   = (reg_hblank == 16'd0) ? 1 : int'(reg_hblank);
        vb   = (reg_vblank == 16'd0) ? 1 : int'(reg_vblank);
        pat  = int'(reg_pattern);
        cst  = int'(reg_const);
        span = sparse + 1;
        for (int v = 0; v < vb; v++) pushExp(which, mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0));
        for (int y = 0; y < lines; y++) begin
            for (int h = 0; h < hb; h++) pushExp(which, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0));
            for (int i = 0; i < pix * span; i++) begin
                de = ((i % span) == 0);
                pushExp(which, mk(de, 1'b0, 1'b1, 1'b1,
                                  (y == lines - 1) && (i == pix * span - 1),
                                  de ? pixelValue(pat, cst, i / span, y) : '0));
            end
        end
    endfunction

    task automatic checkOne(input int which, input logic [PW-1:0] d, input logic de, input logic hs,
                            input logic vs, input logic busy, input logic fe);
        exp_t e;
        vectors++;
        if ((which == 0 && q0.size() == 0) || (which != 0 && q2.size() == 0)) begin
            miscompares++;
            $display("[TB] FAIL model_underrun dut%0d cycle %0d", which, cycle);
            return;
        end
        if (which == 0) e = q0.pop_front();
        else            e = q2.pop_front();
        if ({de, hs, vs, busy, fe, d} !== {e.de, e.hs, e.vs, e.busy, e.fe, e.dout}) begin
            miscompares++;
            $display("[TB] FAIL stream dut%0d cycle %0d got de=%b hs=%b vs=%b busy=%b fe=%b do=%h required de=%b hs=%b vs=%b busy=%b fe=%b do=%h",
                     which, cycle, de, hs, vs, busy, fe, d, e.de, e.hs, e.vs, e.busy, e.fe, e.dout);
        end
    endtask

    task automatic checkOutput();
        checkOne(0, do0, de0, hs0, vs0, busy0, fe0);
        checkOne(2, do2, de2, hs2, vs2, busy2, fe2);
    endtask

    task automatic expectEq(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic en);
        reg_pix_count  = v.pix[15:0];
        reg_line_count = v.lines[15:0];
        reg_hblank     = v.hb[15:0];
        reg_vblank     = v.vb[15:0];
        reg_pattern    = v.pat[1:0];
        reg_const      = v.cst[PW-1:0];
        reg_en         = en;
    endtask

    // Check the current cycle, extend the expected streams, advance a cycle.
    task automatic tick();
        checkOutput();
        if (q0.size() == 0) modelRefill(0, 0);
        if (q2.size() == 0) modelRefill(2, 2);
        @(negedge clk);
        cycle++;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        reg_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q2.delete();
        pushExp(0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        pushExp(2, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    task automatic drainIdle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy0 || busy2) && n < budget) begin
            tick();
            n++;
        end
        expectEq(name, int'(busy0 || busy2), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t cfg_a;
        int   sample, nrise, fe_seen, n, len0, len2;
        int   rise[3];
        logic prev_vs;

        tbl[0] = '{4,    2,  3, 5, 0, 0,      19,    35};
        tbl[1] = '{3,    1,  2, 1, 3, 'hA5A,  6,     12};
        tbl[2] = '{16,   16, 2, 3, 2, 0,      291,   803};
        tbl[3] = '{16,   16, 1, 1, 1, 0,      273,   785};
        tbl[4] = '{5,    3,  0, 0, 0, 0,      19,    49};
        tbl[5] = '{4,    0,  3, 5, 0, 0,      0,     0};
        tbl[6] = '{0,    2,  3, 5, 0, 0,      0,     0};
        tbl[7] = '{4100, 1,  1, 1, 0, 0,      4102,  12302};
        cfg_a  = tbl[0];

        reg_en = 1'b0; reg_pattern = '0; reg_const = '0;
        reg_pix_count = '0; reg_line_count = '0; reg_hblank = '0; reg_vblank = '0;

        // Back-to-back frames, vs timing and a mid-frame reconfiguration.
        doReset();
        applyStimulus(cfg_a, 1'b1);
        sample  = cycle;
        nrise   = 0;
        fe_seen = 0;
        rise    = '{-1000, -1000, -1000};
        prev_vs = vs0;
        for (int k = 0; k < 52; k++) begin
            if (k == 10) begin
                reg_pix_count = 16'd6;
                reg_pattern   = 2'd1;
            end
            tick();
            if (vs0 && !prev_vs && nrise < 3) begin
                rise[nrise] = cycle;
                nrise++;
            end
            if (fe0) fe_seen++;
            prev_vs = vs0;
        end
        expectEq("first_vs_rise", rise[0] - sample, 6);
        expectEq("vs_period_4pix", rise[1] - rise[0], 19);
        expectEq("vs_period_6pix", rise[2] - rise[1], 23);
        expectEq("frame_end_count", fe_seen, 2);

        // Enable dropped during line 0: frame completes, then idle.
        reg_en  = 1'b0;
        fe_seen = 0;
        n       = 0;
        while (busy0 && n < 100) begin
            tick();
            if (fe0) fe_seen++;
            n++;
        end
        expectEq("drain_to_idle", int'(busy0), 0);
        expectEq("frame_end_before_idle", fe_seen, 1);
        expectEq("idle_vs_low", int'(vs0), 0);
        reg_en = 1'b1;
        tick();
        expectEq("restart_vblank", int'({hs0, vs0, busy0}), 5);
        reg_en = 1'b0;
        drainIdle("drain_after_restart", 5000);

        // Asynchronous reset in the middle of the active window.
        applyStimulus(cfg_a, 1'b1);
        n = 0;
        while (!de0 && n < 50) begin
            tick();
            n++;
        end
        expectEq("reach_active", int'(de0), 1);
        rst = 1'b1;
        #1;
        expectEq("async_reset", int'({de0, hs0, vs0, busy0, fe0, do0, de2, hs2, vs2, busy2}), 0);
        doReset();

        // Table of single-frame configurations with hand-computed lengths.
        for (int t = 0; t < 8; t++) begin
            applyStimulus(tbl[t], 1'b1);
            tick();
            reg_en = 1'b0;
            len0 = 0;
            len2 = 0;
            n    = 0;
            while ((busy0 || busy2) && n < 20000) begin
                if (busy0) len0++;
                if (busy2) len2++;
                tick();
                n++;
            end
            expectEq($sformatf("frame_len_sparse0_vec%0d", t), len0, tbl[t].len0);
            expectEq($sformatf("frame_len_sparse2_vec%0d", t), len2, tbl[t].len2);
        end

        // Random register traffic, including changes in the middle of frames.
        doReset();
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                reg_en         = ($urandom_range(0, 9) != 0);
                reg_pix_count  = 16'($urandom_range(0, 10));
                reg_line_count = 16'($urandom_range(0, 3));
                reg_hblank     = 16'($urandom_range(0, 3));
                reg_vblank     = 16'($urandom_range(0, 3));
                reg_pattern    = 2'($urandom_range(0, 3));
                reg_const      = PW'($urandom);
            end
            tick();
        end
        reg_en = 1'b0;
        drainIdle("drain_after_random", 5000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_pattern_tx.md
Name: video_pattern_tx

Overview:
- Video stream source that generates frames in the di/de/hs/vs protocol consumed by the scaler chain.
- hs falling edge marks line start; vs rising edge marks frame start.
- Used as a bench and bring-up stimulus source, and as the in-fabric frame source ahead of the scaler.
- Programmable geometry, blanking, pixel sparseness and test pattern; configuration is latched once per frame.

Parameters:
PIXEL_WIDTH, 12, width of do_o
SPARSE, 0, idle cycles inserted after each valid pixel within a line (0 = de continuous)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
reg_en  input  1  generator enable; sampled only at frame boundaries
reg_pattern  input  2  0 h-ramp, 1 v-ramp, 2 checkerboard 8x8, 3 constant
reg_const  input  PIXEL_WIDTH  value for pattern 3
reg_pix_count  input  16  active pixels per line
reg_line_count  input  16  active lines per frame
reg_hblank  input  16  cycles of hs=1 before each line
reg_vblank  input  16  cycles of vertical blank before the first line
do_o  output  PIXEL_WIDTH  pixel data; valid when de_o=1
de_o  output  1  pixel valid
hs_o  output  1  1 during horizontal blank, 0 during the line active window
vs_o  output  1  0 during vertical blank and idle, 1 from the first hblank through the last active cycle
busy_o  output  1  1 whenever state != IDLE
frame_end_o  output  1  one-cycle pulse on the last active cycle of a frame

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame immediately; no partial-line completion.
- All outputs are registered. Every "for N cycles" below refers to consecutive output cycles.
- Config latch: the reg_* inputs are copied into shadow registers on IDLE->VBLANK and on each last-line->VBLANK transition. Changes to the inputs mid-frame have no effect.
- Shadow values are clamped: a reg_hblank or reg_vblank value of 0 is treated as 1.
- If pix_count=0 or line_count=0, the block stays in IDLE.
- IDLE: de=hs=vs=0. Leaves on reg_en=1 and nonzero counts.
- VBLANK, for vblank cycles: hs=1, vs=0, de=0. Exits to HBLANK with y=0.
- HBLANK, for hblank cycles: hs=1, vs=1, de=0. Exits to ACTIVE with x=0.
- ACTIVE, for pix_count*(SPARSE+1) cycles: hs=0, vs=1.
  - de=1 on the first cycle and then on every (SPARSE+1)th cycle, giving exactly pix_count de pulses.
  - x increments after each de cycle.
- End of ACTIVE, not the last line: y++, go to HBLANK.
- End of ACTIVE, last line: frame_end_o=1 on that cycle. Then:
  - reg_en=1: relatch config and go to VBLANK (vs falls).
  - reg_en=0: go to IDLE.
- Frame length = vblank + line_count*(hblank + pix_count*(SPARSE+1)) cycles.
- Back-to-back frames have no extra gap cycles.
- Pixel data, computed from the current x and y:
  - Pattern 0: x[PIXEL_WIDTH-1:0], wraps modulo 2^PIXEL_WIDTH.
  - Pattern 1: y[PIXEL_WIDTH-1:0].
  - Pattern 2: all ones if x[3]^y[3], otherwise 0.
  - Pattern 3: reg_const as latched.
- do_o is 0 whenever de_o=0.
- The pattern select is part of the frame-latched configuration.
- x and y are 16-bit. The 16'hFFFF counts are legal and must not overflow the internal terminal compare.

Test Plan:
- SPARSE=0, pix=4, lines=2, hblank=3, vblank=5, pattern 0, en=1 held:
  - after reset, vs_o rises 6 cycles after the first en sample (1 latch cycle + 5 vblank);
  - each line shows hs=1 for 3 cycles, then de=1 for 4 cycles with do_o = 0,1,2,3;
  - frame_end_o pulses once per frame;
  - consecutive vs rising edges are exactly 19 cycles apart.
- SPARSE=2, pix=3, lines=1, hblank=2, vblank=1, pattern 3, const=12'hA5A:
  - the active window is 9 cycles with de pattern 100100100 and do_o=12'hA5A on de cycles, 0 otherwise.
- pix=16, lines=16, pattern 2:
  - line 0 shows pixels 0-7 as 0 and pixels 8-15 as 12'hFFF;
  - line 8 shows the inverse;
  - the pattern 1 variant gives do_o=y on every pixel of line y.
- Change reg_pix_count 4->6 and reg_pattern mid-frame:
  - the current frame keeps 4 pixels per line;
  - the next frame uses 6 pixels and the new pattern.
- Drop reg_en during line 0 of a 2-line frame:
  - line 1 still completes and frame_end_o pulses;
  - the block then enters IDLE with busy_o=0 and vs_o=0;
  - re-asserting reg_en starts a new VBLANK.
- Assert rst during ACTIVE: de/hs/vs/busy go to 0 immediately (asynchronously).
- Set reg_line_count=0 with en=1: the block stays in IDLE and never toggles hs.
